// File: rtl/ser_rx_deser.sv
// Serial-in/parallel-out receiver: frames WIDTH-bit words from a strobed bit stream
// using a start marker, either bit order, and a valid/ready output register.
module ser_rx_deser #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             frame_start,
    input  logic             dir,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dl_q, dl_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt_new;
    logic             d_use;
    logic             accept;
    logic             complete;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            out_q       <= '0;
            cnt_q       <= '0;
            dl_q        <= 1'b0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            dl_q        <= dl_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: bit acceptance, word completion and output handshake.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        dl_d        = dl_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        base        = sr_q;
        d_use       = dl_q;
        cnt_new     = cnt_q;
        accept      = 1'b0;
        complete    = 1'b0;

        // Clear first so a same-edge set condition overrides it.
        if (clr_err) begin
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        if (sin_valid) begin
            if (frame_start) begin
                accept  = 1'b1;
                d_use   = dir;
                base    = '0;
                cnt_new = CW'(1);
                if (state_q == SHIFT) begin
                    frame_err_d = 1'b1;
                end
            end else if (state_q == SHIFT) begin
                accept  = 1'b1;
                cnt_new = cnt_q + CW'(1);
            end
        end

        word     = d_use ? {base[WIDTH-2:0], sin} : {sin, base[WIDTH-1:1]};
        complete = accept && (cnt_new == CW'(WIDTH));

        if (accept) begin
            sr_d    = word;
            dl_d    = d_use;
            cnt_d   = cnt_new;
            state_d = SHIFT;
        end

        if (complete) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (!out_valid_q || out_ready) begin
                out_d       = word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule
